oam_dma_arbiter: RTL and testbench

Sequences sprite-memory (OAM) DMA and arbitrates the system bus between the CPU core and the DMA engine. Sits between the CPU's bus port and the memory map: passes CPU traffic through when idle, and on a CPU write to the DMA register halts the CPU and owns the bus. While it owns the bus it copies one 256-byte page into OAM on NES-accurate get/put cycle timing.

---
 rtl/oam_dma_arbiter.sv | 129 ++++++++++++
 tb/tb_oam_dma_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/oam_dma_arbiter.sv
// OAM DMA sequencer and CPU/DMA bus arbiter. CPU traffic passes straight through while idle;
// a write to the DMA register halts the CPU and copies one page into OAM on get/put timing.
module oam_dma_arbiter #(
    parameter logic [15:0] DMA_REGISTER_ADDRESS = 16'h4014,
    parameter int          TRANSFER_LENGTH      = 256
) (
    input  logic        clock_i,
    input  logic        reset_ni,
    input  logic        clock_ready_i,
    input  logic [15:0] cpu_address_i,
    input  logic        cpu_address_valid_i,
    input  logic [7:0]  cpu_data_i,
    input  logic        cpu_data_valid_i,
    output logic [7:0]  cpu_data_o,
    output logic        cpu_data_valid_o,
    output logic        cpu_halt_o,
    output logic [15:0] bus_address_o,
    output logic        bus_address_valid_o,
    output logic [7:0]  bus_data_o,
    output logic        bus_data_valid_o,
    input  logic [7:0]  bus_data_i,
    input  logic        bus_data_valid_i,
    output logic [7:0]  oam_address_o,
    output logic [7:0]  oam_data_o,
    output logic        oam_write_o,
    output logic [2:0]  dbg_state_o
);

    // Handshake: the CPU side is a plain strobe interface with no back-pressure; the CPU
    // itself must gate its cycle enable with cpu_halt_o. The bus read side completes on
    // any tick where bus_data_valid_i is high while the read address is presented.

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HALT  = 3'd1,
        S_ALIGN = 3'd2,
        S_READ  = 3'd3,
        S_WRITE = 3'd4
    } state_t;

    localparam logic [7:0] LAST_INDEX = 8'(TRANSFER_LENGTH - 1);

    state_t     r_state;
    state_t     w_next_state;
    logic       r_parity;
    logic [7:0] r_page;
    logic [7:0] r_index;
    logic [7:0] r_byte;
    logic       w_trigger;

    assign w_trigger = (r_state == S_IDLE) && cpu_address_valid_i && cpu_data_valid_i
                       && (cpu_address_i == DMA_REGISTER_ADDRESS);

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_state  <= S_IDLE;
            r_parity <= 1'b0;
            r_page   <= 8'd0;
            r_index  <= 8'd0;
            r_byte   <= 8'd0;
        end else if (clock_ready_i) begin
            r_state  <= w_next_state;
            r_parity <= ~r_parity;
            if (w_trigger) begin
                r_page  <= cpu_data_i;
                r_index <= 8'd0;
            end
            if ((r_state == S_READ) && bus_data_valid_i) begin
                r_byte <= bus_data_i;
            end
            // index never carries into page; it only restarts on the next trigger
            if ((r_state == S_WRITE) && (r_index != LAST_INDEX)) begin
                r_index <= r_index + 8'd1;
            end
        end
    end

    always_comb begin
        w_next_state        = r_state;
        cpu_data_o          = bus_data_i;
        cpu_data_valid_o    = 1'b0;
        cpu_halt_o          = 1'b1;
        bus_address_o       = 16'd0;
        bus_address_valid_o = 1'b0;
        bus_data_o          = 8'd0;
        bus_data_valid_o    = 1'b0;
        oam_address_o       = r_index;
        oam_data_o          = r_byte;
        oam_write_o         = 1'b0;

        case (r_state)
            S_IDLE: begin
                cpu_halt_o          = 1'b0;
                cpu_data_valid_o    = bus_data_valid_i;
                bus_address_o       = cpu_address_i;
                bus_address_valid_o = cpu_address_valid_i;
                bus_data_o          = cpu_data_i;
                bus_data_valid_o    = cpu_data_valid_i;
                if (w_trigger) begin
                    w_next_state = S_HALT;
                end
            end
            S_HALT: begin
                // parity==1 here means the next tick is a get cycle
                w_next_state = r_parity ? S_READ : S_ALIGN;
            end
            S_ALIGN: begin
                w_next_state = S_READ;
            end
            S_READ: begin
                bus_address_o       = {r_page, r_index};
                bus_address_valid_o = 1'b1;
                if (bus_data_valid_i) begin
                    w_next_state = S_WRITE;
                end
            end
            S_WRITE: begin
                oam_write_o  = clock_ready_i;
                w_next_state = (r_index == LAST_INDEX) ? S_IDLE : S_READ;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    assign dbg_state_o = r_state;

endmodule

// File: tb/tb_oam_dma_arbiter.sv
// Directed bench for oam_dma_arbiter: passthrough, aligned/unaligned transfers, page FF,
// read stall, tick gating, ignored re-trigger and reset abort.
module tb_oam_dma_arbiter;

  logic        clk;
  logic        rst_n;
  logic        clock_ready;
  logic [15:0] cpu_address;
  logic        cpu_address_valid;
  logic [7:0]  cpu_data;
  logic        cpu_data_valid;
  logic [7:0]  cpu_data_o;
  logic        cpu_data_valid_o;
  logic        cpu_halt;
  logic [15:0] bus_address;
  logic        bus_address_valid;
  logic [7:0]  bus_data_o;
  logic        bus_data_valid_o;
  logic [7:0]  bus_data_i;
  logic        bus_data_valid_i;
  logic [7:0]  oam_address;
  logic [7:0]  oam_data;
  logic        oam_write;
  logic [2:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  // bench-side memory and stall controls
  logic       use_mem;
  logic [7:0] pt_data;
  logic       bdv;

  // monitor state
  int  tick_cnt;
  int  halt_ticks;
  int  gate_err;
  bit  saw_zero;
  logic [15:0] obs_q[$];
  logic [15:0] rd_q[$];
  logic [15:0] exp_q[$];

  // results of the last run_dma
  bit r_timeout;
  int r_exp_halt;
  bit r_pre_halt;
  bit r_post_halt;
  bit r_fwd_ok;
  bit r_stall_bad;

  function automatic logic [7:0] mem(input logic [15:0] a);
    return a[7:0] ^ 8'hA5 ^ a[15:8] ^ 8'h02;
  endfunction

  assign bus_data_i       = use_mem ? mem(bus_address) : pt_data;
  assign bus_data_valid_i = bdv;

  oam_dma_arbiter dut (
    .clock_i             (clk),
    .reset_ni            (rst_n),
    .clock_ready_i       (clock_ready),
    .cpu_address_i       (cpu_address),
    .cpu_address_valid_i (cpu_address_valid),
    .cpu_data_i          (cpu_data),
    .cpu_data_valid_i    (cpu_data_valid),
    .cpu_data_o          (cpu_data_o),
    .cpu_data_valid_o    (cpu_data_valid_o),
    .cpu_halt_o          (cpu_halt),
    .bus_address_o       (bus_address),
    .bus_address_valid_o (bus_address_valid),
    .bus_data_o          (bus_data_o),
    .bus_data_valid_o    (bus_data_valid_o),
    .bus_data_i          (bus_data_i),
    .bus_data_valid_i    (bus_data_valid_i),
    .oam_address_o       (oam_address),
    .oam_data_o          (oam_data),
    .oam_write_o         (oam_write),
    .dbg_state_o         (dbg_state)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // mid-cycle monitor: everything seen here applies to the coming rising edge
  always @(negedge clk) begin
    if (!rst_n) begin
      tick_cnt = 0;
    end else if (clock_ready) begin
      tick_cnt = tick_cnt + 1;
      if (cpu_halt) halt_ticks = halt_ticks + 1;
      if (oam_write) obs_q.push_back({oam_address, oam_data});
      if (cpu_halt && bus_address_valid && bdv) rd_q.push_back(bus_address);
    end
    if (oam_write && !clock_ready) gate_err = gate_err + 1;
    if (cpu_halt && bus_address_valid && bus_address == 16'h0000) saw_zero = 1;
  end

  task automatic idle_cpu();
    cpu_address       = 16'h0000;
    cpu_address_valid = 1'b0;
    cpu_data          = 8'h00;
    cpu_data_valid    = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Drives one transfer to completion; want_halt_par < 0 means any alignment.
  task automatic run_dma(input logic [7:0] page, input int want_halt_par, input int stall_idx,
                         input bit gate, input bit retrigger);
    int stall_cnt;
    bit stall_done;
    obs_q.delete(); rd_q.delete(); exp_q.delete();
    halt_ticks = 0; gate_err = 0; saw_zero = 0;
    r_timeout = 1; r_stall_bad = 0;
    stall_cnt = 0; stall_done = 0;
    for (int i = 0; i < 256; i++) exp_q.push_back({8'(i), mem({page, 8'(i)})});
    @(posedge clk); #1;
    if (want_halt_par >= 0) begin
      while ((tick_cnt % 2) != (1 - want_halt_par)) begin
        @(posedge clk); #1;
      end
    end
    r_exp_halt = 513 + (tick_cnt % 2) + ((stall_idx >= 0) ? 3 : 0);
    cpu_address = 16'h4014; cpu_address_valid = 1'b1;
    cpu_data = page; cpu_data_valid = 1'b1;
    #1;
    r_pre_halt = cpu_halt;
    r_fwd_ok = (bus_address == 16'h4014) && bus_address_valid && bus_data_valid_o
               && (bus_data_o == page);
    @(posedge clk); #1;
    idle_cpu();
    r_post_halt = cpu_halt;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk); #1;
      if (gate) clock_ready = (c % 3 != 2);
      if (retrigger && c == 100) begin
        cpu_address = 16'h4014; cpu_address_valid = 1'b1;
        cpu_data = 8'h77; cpu_data_valid = 1'b1;
      end
      if (retrigger && c == 103) idle_cpu();
      if (stall_cnt > 0) begin
        if (!(bus_address_valid && bus_address == {page, 8'(stall_idx)})) r_stall_bad = 1;
        stall_cnt = stall_cnt - 1;
        if (stall_cnt == 0) begin
          bdv = 1'b1; use_mem = 1'b1;
        end
      end else if (stall_idx >= 0 && !stall_done && cpu_halt && bus_address_valid
                   && bus_address[7:0] == 8'(stall_idx)) begin
        stall_done = 1; stall_cnt = 3;
        bdv = 1'b0; use_mem = 1'b0; pt_data = 8'hEE;
      end
      if (!cpu_halt) begin
        r_timeout = 0;
        break;
      end
    end
    clock_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clock_ready = 1'b1;
    use_mem = 1'b1; pt_data = 8'h00; bdv = 1'b1;
    cpu_address = 16'h1234; cpu_address_valid = 1'b1;
    cpu_data = 8'h9C; cpu_data_valid = 1'b0;
    halt_ticks = 0; gate_err = 0; saw_zero = 0; tick_cnt = 0;
    #12;
    checks++; if (cpu_halt !== 1'b0) begin errors++; $display("FAIL reset_halt got=%b exp=0", cpu_halt); end
    checks++; if (oam_write !== 1'b0) begin errors++; $display("FAIL reset_oam_write got=%b exp=0", oam_write); end
    checks++; if ({oam_address, oam_data} !== 16'h0000) begin errors++; $display("FAIL reset_oam_addr_data got=%h exp=0000", {oam_address, oam_data}); end
    checks++; if (bus_address !== 16'h1234 || bus_address_valid !== 1'b1) begin errors++; $display("FAIL reset_passthrough got=%h/%b exp=1234/1", bus_address, bus_address_valid); end
    checks++; if (dbg_state !== 3'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
    @(posedge clk); #1 rst_n = 1'b1;
    idle_cpu();
  endtask

  task automatic test_passthrough();
    int writes;
    obs_q.delete();
    @(posedge clk); #1;
    use_mem = 1'b0; pt_data = 8'h5A;
    cpu_address = 16'h8000; cpu_address_valid = 1'b1;
    #1;
    checks++; if (bus_address !== 16'h8000 || bus_address_valid !== 1'b1 || bus_data_valid_o !== 1'b0) begin errors++; $display("FAIL pt_read_bus got=%h/%b/%b exp=8000/1/0", bus_address, bus_address_valid, bus_data_valid_o); end
    checks++; if (cpu_data_o !== 8'h5A || cpu_data_valid_o !== 1'b1) begin errors++; $display("FAIL pt_read_data got=%h/%b exp=5a/1", cpu_data_o, cpu_data_valid_o); end
    @(posedge clk); #1;
    cpu_address = 16'h4015; cpu_data = 8'h3C; cpu_data_valid = 1'b1;
    #1;
    checks++; if (bus_address !== 16'h4015 || bus_data_o !== 8'h3C || bus_data_valid_o !== 1'b1) begin errors++; $display("FAIL pt_write got=%h/%h/%b exp=4015/3c/1", bus_address, bus_data_o, bus_data_valid_o); end
    @(posedge clk); #1;
    idle_cpu(); use_mem = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    writes = obs_q.size();
    checks++; if (cpu_halt !== 1'b0 || writes != 0) begin errors++; $display("FAIL pt_no_dma halt=%b writes=%0d exp=0/0", cpu_halt, writes); end
  endtask

  task automatic check_contents(input string name);
    int nbad;
    int first;
    nbad = 0; first = -1;
    for (int i = 0; i < 256; i++) begin
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
        if (first < 0) first = i;
        nbad++;
      end
    end
    checks++;
    if (nbad != 0 || obs_q.size() != 256) begin
      errors++;
      $display("FAIL %s_oam got=%0d writes, %0d bad (first %0d) exp=256 writes, 0 bad", name, obs_q.size(), nbad, first);
    end
  endtask

  task automatic test_even_dma();
    run_dma(8'h02, 1, -1, 0, 0);
    checks++; if (r_timeout) begin errors++; $display("FAIL even_timeout got=timeout exp=done"); end
    checks++; if (r_pre_halt !== 1'b0 || r_post_halt !== 1'b1) begin errors++; $display("FAIL even_halt_edge got=%b->%b exp=0->1", r_pre_halt, r_post_halt); end
    checks++; if (!r_fwd_ok) begin errors++; $display("FAIL even_trigger_fwd got=0 exp=1"); end
    checks++; if (halt_ticks != 513) begin errors++; $display("FAIL even_halt_len got=%0d exp=513", halt_ticks); end
    check_contents("even");
  endtask

  task automatic test_odd_dma();
    run_dma(8'h02, 0, -1, 0, 0);
    checks++; if (halt_ticks != 514 || r_timeout) begin errors++; $display("FAIL odd_halt_len got=%0d exp=514", halt_ticks); end
    check_contents("odd");
  endtask

  task automatic test_page_ff();
    int nbad;
    run_dma(8'hFF, -1, -1, 0, 0);
    nbad = 0;
    for (int i = 0; i < 256; i++) begin
      if (i >= rd_q.size() || rd_q[i] !== {8'hFF, 8'(i)}) nbad++;
    end
    checks++; if (nbad != 0 || rd_q.size() != 256) begin errors++; $display("FAIL ff_read_order got=%0d reads, %0d bad exp=256 reads, 0 bad", rd_q.size(), nbad); end
    checks++; if (saw_zero) begin errors++; $display("FAIL ff_no_zero got=1 exp=0"); end
    check_contents("ff");
    repeat (5) @(posedge clk);
    #1;
    checks++; if (cpu_halt !== 1'b0 || dbg_state !== 3'd0 || r_timeout) begin errors++; $display("FAIL ff_idle got=%b/%0d exp=0/0", cpu_halt, dbg_state); end
  endtask

  task automatic test_read_stall();
    run_dma(8'h02, -1, 10, 0, 0);
    checks++; if (r_stall_bad) begin errors++; $display("FAIL stall_addr_hold got=moved exp=020a"); end
    checks++; if (halt_ticks != r_exp_halt || r_timeout) begin errors++; $display("FAIL stall_halt_len got=%0d exp=%0d", halt_ticks, r_exp_halt); end
    check_contents("stall");
  endtask

  task automatic test_tick_gate();
    run_dma(8'h02, -1, -1, 1, 0);
    checks++; if (gate_err != 0) begin errors++; $display("FAIL gate_write_between_ticks got=%0d exp=0", gate_err); end
    checks++; if (halt_ticks != r_exp_halt || r_timeout) begin errors++; $display("FAIL gate_halt_len got=%0d exp=%0d", halt_ticks, r_exp_halt); end
    check_contents("gate");
  endtask

  task automatic test_retrigger_ignored();
    int extra;
    run_dma(8'h02, -1, -1, 0, 1);
    check_contents("retrig");
    extra = 0;
    repeat (10) begin
      @(negedge clk);
      if (cpu_halt) extra++;
    end
    checks++; if (extra != 0 || r_timeout) begin errors++; $display("FAIL retrig_no_restart got=%0d halted cycles exp=0", extra); end
  endtask

  task automatic test_reset_abort();
    bit hit;
    int writes;
    obs_q.delete();
    @(posedge clk); #1;
    cpu_address = 16'h4014; cpu_address_valid = 1'b1;
    cpu_data = 8'h02; cpu_data_valid = 1'b1;
    @(posedge clk); #1;
    idle_cpu();
    hit = 0;
    for (int c = 0; c < 1000; c++) begin
      @(posedge clk); #2;
      if (obs_q.size() >= 101) begin hit = 1; break; end
    end
    checks++; if (!hit) begin errors++; $display("FAIL abort_reach_write100 got=timeout exp=101 writes"); end
    rst_n = 1'b0;
    #1;
    checks++; if (cpu_halt !== 1'b0 || oam_write !== 1'b0) begin errors++; $display("FAIL abort_immediate got=halt %b write %b exp=0/0", cpu_halt, oam_write); end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    writes = obs_q.size();
    checks++; if (writes != 101 || cpu_halt !== 1'b0) begin errors++; $display("FAIL abort_no_more_writes got=%0d/%b exp=101/0", writes, cpu_halt); end
    use_mem = 1'b0; pt_data = 8'h5A;
    cpu_address = 16'h8000; cpu_address_valid = 1'b1;
    #1;
    checks++; if (bus_address !== 16'h8000 || cpu_data_o !== 8'h5A || cpu_data_valid_o !== 1'b1) begin errors++; $display("FAIL abort_passthrough got=%h/%h/%b exp=8000/5a/1", bus_address, cpu_data_o, cpu_data_valid_o); end
    @(posedge clk); #1;
    idle_cpu(); use_mem = 1'b1;
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_even_dma();
    test_odd_dma();
    test_page_ff();
    test_read_stall();
    test_tick_gate();
    test_retrigger_ignored();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
